// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, opcodes and next-state rule.
package jtag_pkg;

   localparam int IR_W = 8;

   localparam logic [IR_W-1:0] IR_IDCODE = 8'hE0;
   localparam logic [IR_W-1:0] IR_ER1    = 8'h32;
   localparam logic [IR_W-1:0] IR_ER2    = 8'h38;
   localparam logic [IR_W-1:0] IR_BYPASS = 8'hFF;

   typedef enum logic [3:0] {
      TAP_TLR    = 4'h0,
      TAP_RTI    = 4'h1,
      TAP_SEL_DR = 4'h2,
      TAP_CAP_DR = 4'h3,
      TAP_SH_DR  = 4'h4,
      TAP_EX1_DR = 4'h5,
      TAP_PSE_DR = 4'h6,
      TAP_EX2_DR = 4'h7,
      TAP_UPD_DR = 4'h8,
      TAP_SEL_IR = 4'h9,
      TAP_CAP_IR = 4'hA,
      TAP_SH_IR  = 4'hB,
      TAP_EX1_IR = 4'hC,
      TAP_PSE_IR = 4'hD,
      TAP_EX2_IR = 4'hE,
      TAP_UPD_IR = 4'hF
   } tap_state_e;

   function automatic tap_state_e tap_next(tap_state_e s, logic tms);
      tap_state_e n;
      n = TAP_TLR;
      unique case (s)
         TAP_TLR:    n = tms ? TAP_TLR    : TAP_RTI;
         TAP_RTI:    n = tms ? TAP_SEL_DR : TAP_RTI;
         TAP_SEL_DR: n = tms ? TAP_SEL_IR : TAP_CAP_DR;
         TAP_CAP_DR: n = tms ? TAP_EX1_DR : TAP_SH_DR;
         TAP_SH_DR:  n = tms ? TAP_EX1_DR : TAP_SH_DR;
         TAP_EX1_DR: n = tms ? TAP_UPD_DR : TAP_PSE_DR;
         TAP_PSE_DR: n = tms ? TAP_EX2_DR : TAP_PSE_DR;
         TAP_EX2_DR: n = tms ? TAP_UPD_DR : TAP_SH_DR;
         TAP_UPD_DR: n = tms ? TAP_SEL_DR : TAP_RTI;
         TAP_SEL_IR: n = tms ? TAP_TLR    : TAP_CAP_IR;
         TAP_CAP_IR: n = tms ? TAP_EX1_IR : TAP_SH_IR;
         TAP_SH_IR:  n = tms ? TAP_EX1_IR : TAP_SH_IR;
         TAP_EX1_IR: n = tms ? TAP_UPD_IR : TAP_PSE_IR;
         TAP_PSE_IR: n = tms ? TAP_EX2_IR : TAP_PSE_IR;
         TAP_EX2_IR: n = tms ? TAP_UPD_IR : TAP_SH_IR;
         TAP_UPD_IR: n = tms ? TAP_SEL_DR : TAP_RTI;
         default:    n = TAP_TLR;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller with registered capture/shift/update strobes.
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic       tck,
   input  logic       trst_n,
   input  logic       tms,
   output tap_state_e state,
   output logic       cap_ir,
   output logic       sh_ir,
   output logic       upd_ir,
   output logic       cap_dr,
   output logic       sh_dr,
   output logic       upd_dr
);

   tap_state_e nxt;

   assign nxt = tap_next(state, tms);

   // strobes are registered from the next state so they match the state reg
   always_ff @(posedge tck) begin
      if (!trst_n) begin
         state  <= TAP_TLR;
         cap_ir <= 1'b0;
         sh_ir  <= 1'b0;
         upd_ir <= 1'b0;
         cap_dr <= 1'b0;
         sh_dr  <= 1'b0;
         upd_dr <= 1'b0;
      end else begin
         state  <= nxt;
         cap_ir <= (nxt == TAP_CAP_IR);
         sh_ir  <= (nxt == TAP_SH_IR);
         upd_ir <= (nxt == TAP_UPD_IR);
         cap_dr <= (nxt == TAP_CAP_DR);
         sh_dr  <= (nxt == TAP_SH_DR);
         upd_dr <= (nxt == TAP_UPD_DR);
      end
   end

endmodule

// File: rtl/jtag_if.sv
// JTAG TAP with IDCODE, ER1 module-select and ER2 user data registers.
module jtag_if
   import jtag_pkg::*;
#(
   parameter logic [31:0] IDCODE_VAL = 32'h41111043,
   parameter int          SEL_W      = 3,
   parameter int          ER2_W      = 32
)(
   input  logic             TCK,
   input  logic             TRST_N,
   input  logic             TMS,
   input  logic             TDI,
   output logic             TDO,
   output logic [SEL_W-1:0] SEL_MODULE,
   output logic [ER2_W-1:0] ER2_DATA,
   output logic             ER2_UPDATE
);

   localparam int W1   = (ER2_W > 32) ? ER2_W : 32;
   localparam int DR_W = (SEL_W > W1) ? SEL_W : W1;

   tap_state_e      state;
   logic            cap_ir;
   logic            sh_ir;
   logic            upd_ir;
   logic            cap_dr;
   logic            sh_dr;
   logic            upd_dr;
   logic            tlr;
   logic [IR_W-1:0] ir;
   logic [IR_W-1:0] ir_sr;
   logic [DR_W-1:0] dr_sr;
   logic [DR_W-1:0] dr_cap;
   logic [DR_W-1:0] dr_nxt;
   logic [DR_W-1:0] dr_shr;
   int              act_w;

   jtag_tap_fsm u_fsm (
      .tck    (TCK),
      .trst_n (TRST_N),
      .tms    (TMS),
      .state  (state),
      .cap_ir (cap_ir),
      .sh_ir  (sh_ir),
      .upd_ir (upd_ir),
      .cap_dr (cap_dr),
      .sh_dr  (sh_dr),
      .upd_dr (upd_dr)
   );

   assign tlr    = (state == TAP_TLR);
   assign dr_shr = dr_sr >> 1;

   always_comb begin
      dr_cap = '0;
      act_w  = 1;
      unique case (1'b1)
         (ir == IR_IDCODE): begin
            dr_cap = DR_W'(IDCODE_VAL);
            act_w  = 32;
         end
         (ir == IR_ER1): begin
            dr_cap = DR_W'(SEL_MODULE);
            act_w  = SEL_W;
         end
         (ir == IR_ER2): begin
            dr_cap = DR_W'(ER2_DATA);
            act_w  = ER2_W;
         end
         default: begin
            dr_cap = '0;
            act_w  = 1;
         end
      endcase
   end

   // TDI lands at the top of the active width; bits above it are left alone
   always_comb begin
      dr_nxt = dr_sr;
      for (int i = 0; i < DR_W; i++) begin
         if (i == act_w - 1)
            dr_nxt[i] = TDI;
         else if (i < act_w - 1)
            dr_nxt[i] = dr_shr[i];
      end
   end

   always_ff @(posedge TCK) begin
      if (!TRST_N || tlr) begin
         ir         <= IR_IDCODE;
         ir_sr      <= '0;
         dr_sr      <= '0;
         SEL_MODULE <= '0;
         ER2_DATA   <= '0;
         ER2_UPDATE <= 1'b0;
      end else begin
         ER2_UPDATE <= 1'b0;
         if (cap_ir)
            ir_sr <= IR_W'(1);
         else if (sh_ir)
            ir_sr <= {TDI, ir_sr[IR_W-1:1]};
         if (upd_ir)
            ir <= ir_sr;
         if (cap_dr)
            dr_sr <= dr_cap;
         else if (sh_dr)
            dr_sr <= dr_nxt;
         if (upd_dr && ir == IR_ER1)
            SEL_MODULE <= dr_sr[SEL_W-1:0];
         if (upd_dr && ir == IR_ER2) begin
            ER2_DATA   <= dr_sr[ER2_W-1:0];
            ER2_UPDATE <= 1'b1;
         end
      end
   end

   assign TDO = sh_ir ? ir_sr[0] : (sh_dr ? dr_sr[0] : 1'b0);

endmodule

// File: tb/tb_jtag_if.sv
// Scoreboard bench for jtag_if: queue-based shift model, negedge monitor.
module tb_jtag_if;

   localparam logic [31:0] IDC = 32'h41111043;

   logic        tck = 1'b0;
   logic        trst_n = 1'b0;
   logic        tms = 1'b1;
   logic        tdi = 1'b0;
   logic        tdo;
   logic [2:0]  sel;
   logic [31:0] er2d;
   logic        er2u;

   jtag_if dut (
      .TCK        (tck),
      .TRST_N     (trst_n),
      .TMS        (tms),
      .TDI        (tdi),
      .TDO        (tdo),
      .SEL_MODULE (sel),
      .ER2_DATA   (er2d),
      .ER2_UPDATE (er2u)
   );

   always #5 tck = ~tck;

   int          total = 0;
   int          bad = 0;
   bit          exp_q[$];
   logic [31:0] upd_q[$];
   bit          chk = 1'b0;
   logic [7:0]  m_ir;
   logic [2:0]  m_sel;
   logic [31:0] m_er2;

   task automatic check(input string name, input logic [63:0] got,
                        input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   always @(negedge tck) begin
      if (chk)
         check("tdo", {63'd0, tdo}, {63'd0, exp_q.pop_front()});
      if (er2u === 1'b1) begin
         if (upd_q.size() > 0)
            check("er2_pulse_data", {32'd0, er2d}, {32'd0, upd_q.pop_front()});
         else
            check("er2_pulse_extra", {63'd0, er2u}, 64'd0);
      end
   end

   task automatic step(input logic t, input logic d, input bit c, input bit e);
      tms = t;
      tdi = d;
      if (c) begin
         exp_q.push_back(e);
         chk = 1'b1;
      end
      @(posedge tck);
      #1;
      chk = 1'b0;
   endtask

   task automatic model_reset();
      m_ir  = 8'hE0;
      m_sel = 3'd0;
      m_er2 = 32'd0;
   endtask

   // Full scan from Run-Test/Idle back to Run-Test/Idle; shift reg is a queue.
   task automatic scan(input bit is_ir, input int n, input logic [63:0] din,
                       input int pause_at);
      bit          q[$];
      int          w;
      logic [63:0] cap;
      logic [63:0] val;
      if (is_ir) begin
         w = 8; cap = 64'h1;
      end else begin
         case (m_ir)
            8'hE0:   begin w = 32; cap = {32'd0, IDC};   end
            8'h32:   begin w = 3;  cap = {61'd0, m_sel}; end
            8'h38:   begin w = 32; cap = {32'd0, m_er2}; end
            default: begin w = 1;  cap = 64'd0;          end
         endcase
      end
      for (int i = 0; i < w; i++) q.push_back(cap[i]);
      step(1, 0, 1, 0);
      if (is_ir) step(1, 0, 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      for (int i = 0; i < n; i++) begin
         step((i == n - 1) || (i == pause_at), din[i], 1, q[0]);
         void'(q.pop_front());
         q.push_back(din[i]);
         if (i == pause_at && i != n - 1) begin
            step(0, 0, 1, 0);
            step(0, 0, 1, 0);
            step(1, 0, 1, 0);
            step(0, 0, 1, 0);
         end
      end
      val = 64'd0;
      for (int i = 0; i < w; i++) val[i] = q[i];
      if (is_ir)
         m_ir = val[7:0];
      else if (m_ir == 8'h32)
         m_sel = val[2:0];
      else if (m_ir == 8'h38) begin
         m_er2 = val[31:0];
         upd_q.push_back(val[31:0]);
      end
      step(1, 0, 1, 0);
      step(0, 0, 1, 0);
   endtask

   task automatic check_regs(input string tag);
      check({tag, "_sel"}, {61'd0, sel}, {61'd0, m_sel});
      check({tag, "_er2"}, {32'd0, er2d}, {32'd0, m_er2});
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ops[4];
      logic [7:0] op;
      int         n;
      ops[0] = 8'hE0; ops[1] = 8'h32; ops[2] = 8'h38; ops[3] = 8'hFF;
      model_reset();
      trst_n = 1'b0;
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      check("rst_tdo", {63'd0, tdo}, 64'd0);
      check("rst_upd", {63'd0, er2u}, 64'd0);
      check_regs("rst");
      trst_n = 1'b1;
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
      step(0, 0, 1, 0);
      scan(1, 8, 64'hE0, -1);
      scan(0, 32, {32'd0, $urandom}, -1);
      check_regs("idcode");
      scan(1, 8, 64'h38, -1);
      scan(1, 8, 64'h32, -1);
      scan(0, 3, 64'b110, -1);
      check_regs("er1_a");
      scan(0, 3, 64'b100, -1);
      check_regs("er1_b");
      scan(0, 3, 64'b101, -1);
      check_regs("er1_c");
      scan(1, 8, 64'h38, -1);
      scan(0, 32, 64'hDEADBEEF, -1);
      check_regs("er2_a");
      scan(0, 32, {32'd0, $urandom}, -1);
      check_regs("er2_b");
      scan(0, 32, {32'd0, $urandom}, 10);
      check_regs("er2_pause");
      scan(1, 8, 64'hFF, -1);
      scan(0, 8, 64'hA5, -1);
      check_regs("bypass");
      scan(1, 8, 64'h32, -1);
      scan(0, 2, 64'b01, -1);
      check_regs("er1_partial");
      for (int k = 0; k < 24; k++) begin
         op = ($urandom_range(0, 4) == 4) ? 8'($urandom) : ops[$urandom_range(0, 3)];
         scan(1, 8, {56'd0, op}, $urandom_range(0, 8));
         n = $urandom_range(1, 40);
         scan(0, n, {$urandom, $urandom}, $urandom_range(0, n));
         check_regs("rand");
      end
      // reset in the middle of a Shift-DR
      scan(1, 8, 64'h38, -1);
      scan(0, 32, 64'h12345678, -1);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
      trst_n = 1'b0;
      step(0, 1, 0, 0);
      trst_n = 1'b1;
      model_reset();
      check("trst_tdo", {63'd0, tdo}, 64'd0);
      check_regs("trst");
      step(0, 0, 1, 0);
      scan(0, 32, {32'd0, $urandom}, -1);
      check_regs("post_trst");
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      check("tdo_q_left", 64'(exp_q.size()), 64'd0);
      check("er2_pulse_missing", 64'(upd_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jtag_if.md
Name: jtag_if

Overview:
- IEEE 1149.1-style TAP for the debug path: 16-state TAP controller, 8-bit instruction register, and a set of data registers.
- ECP5-style user instructions: ER1 (0x32) holds a 3-bit module-select register; ER2 (0x38) holds a 32-bit user data register tagged with the current selection.
- Sits between the external JTAG pins and the debug modules; SEL_MODULE steers downstream module muxing.

Parameters:
- IDCODE_VAL, 32'h41111043, value loaded into the IDCODE DR on Capture-DR.
- SEL_W, 3, module-select register width.
- ER2_W, 32, ER2 data register width.

Ports:
- TCK  in  1  the single clock; all state updates on rising edge.
- TRST_N  in  1  reset, synchronous, active-low, sampled on TCK rising edge.
- TMS  in  1  TAP mode select.
- TDI  in  1  serial data in.
- TDO  out  1  serial data out.
- SEL_MODULE  out  SEL_W  currently selected module.
- ER2_DATA  out  ER2_W  last value written via ER2.
- ER2_UPDATE  out  1  one-cycle pulse in the cycle after Update-DR with IR=ER2.

Behaviour:
- Reset (TRST_N=0 at TCK rising edge) sets:
  - TAP state = Test-Logic-Reset
  - IR = IDCODE (8'hE0)
  - SEL_MODULE = 0, ER2_DATA = 0, ER2_UPDATE = 0
  - all shift registers = 0
- TMS held high for 5 TCK cycles reaches Test-Logic-Reset from any state. Entering Test-Logic-Reset has the same effect on IR, SEL_MODULE and ER2_DATA as TRST_N.
- TAP FSM: standard 16 states (TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, and the IR equivalents). Transitions follow IEEE 1149.1 on TMS at the TCK rising edge.
- IR path:
  - Capture-IR loads 8'b00000001 into the IR shift register.
  - Shift-IR shifts LSB first: shreg <= {TDI, shreg[7:1]}.
  - Update-IR copies the shift register into IR.
- Instruction decode (IR selects the DR path):
  - 0xE0 IDCODE: 32-bit DR.
  - 0x32 ER1: SEL_W-bit DR.
  - 0x38 ER2: ER2_W-bit DR.
  - any other value: BYPASS, 1-bit DR captured as 0.
- DR path:
  - Capture-DR loads the selected register: IDCODE_VAL, SEL_MODULE, ER2_DATA, or 0 for BYPASS.
  - Shift-DR shifts LSB first into a shift register of the active width; TDI enters the MSB of the active width.
  - Update-DR: ER1 writes the shift register to SEL_MODULE. ER2 writes ER2_DATA and pulses ER2_UPDATE for one cycle. IDCODE and BYPASS have no update.
- TDO:
  - Combinational: the LSB of the active shift register while in Shift-IR or Shift-DR.
  - 0 in every other state.
  - The first bit is therefore visible before the first shift edge.
- Pause and Exit2 states hold all shift contents; resuming Shift continues without loss.
- Exiting via Exit1 to Update with fewer bits shifted than the DR width is allowed; the partially shifted value is committed.
- An IR change does not alter SEL_MODULE or ER2_DATA.

Decomposition:
- Package jtag_pkg holds:
  - TAP state enum (4-bit encoding)
  - IR opcode constants: IR_IDCODE=8'hE0, IR_ER1=8'h32, IR_ER2=8'h38, IR_BYPASS=8'hFF
  - IR_W=8
- Sub-module jtag_tap_fsm: takes TCK, TRST_N and TMS; outputs the state plus decoded capture/shift/update strobes for IR and DR.
- DR muxing and registers stay in jtag_if.

Test Plan:
- TMS=1 for 5 TCK, then IR scan with IDCODE, then 32-bit DR scan → TDO stream LSB-first equals IDCODE_VAL; SEL_MODULE=0.
- IR scan 0x38 then IR scan 0x32 (IR capture output = 8'b00000001 on the first TDO bits each time) → final IR=0x32.
- ER1: DR 3'b110 → SEL_MODULE=3'b110 after Update-DR; next DR 3'b100 shifts out 110 LSB-first (0,1,1) on TDO, then SEL_MODULE=3'b100; DR 3'b101 shifts out 0,0,1, then SEL_MODULE=3'b101.
- ER2: IR 0x38, DR 32'hDEADBEEF → ER2_DATA=32'hDEADBEEF, ER2_UPDATE high exactly one cycle; second scan returns DEADBEEF on TDO.
- BYPASS: IR 0xFF, shift 8 bits 8'hA5 → TDO returns 0 followed by the TDI pattern delayed by one bit.
- Reset: TRST_N=0 for one cycle during Shift-DR → state TLR, IR=0xE0, SEL_MODULE=0, ER2_DATA=0, TDO=0.
